// File: rtl/mine_placer_ctl_if.sv
// Game-FSM request/status and board-RAM access signals of the mine placer.
// slave is the placer's view; master is the game-FSM/RAM side.
interface mine_placer_ctl_if #(
  parameter int COORD_W = 6,
  parameter int MINE_W  = 7
);
  logic               start;
  logic [4:0]         dimension_size;
  logic [MINE_W-1:0]  mine_count;
  logic [COORD_W-1:0] safe_x;
  logic [COORD_W-1:0] safe_y;
  logic [COORD_W-1:0] cell_x;
  logic [COORD_W-1:0] cell_y;
  logic               cell_we;
  logic               cell_wdata;
  logic               cell_rd_en;
  logic               cell_rdata;
  logic               busy;
  logic               done;
  logic               error;

  modport slave (
    input  start, dimension_size, mine_count, safe_x, safe_y, cell_rdata,
    output cell_x, cell_y, cell_we, cell_wdata, cell_rd_en, busy, done, error
  );

  modport master (
    output start, dimension_size, mine_count, safe_x, safe_y, cell_rdata,
    input  cell_x, cell_y, cell_we, cell_wdata, cell_rd_en, busy, done, error
  );
endinterface

// File: rtl/mine_placer_ctl.sv
// Saper board generator: clears the cell RAM in row-major order, then places
// mine_count distinct LFSR-chosen mines that never land on the safe cell.
module mine_placer_ctl #(
  parameter int          COORD_W   = 6,
  parameter int          MINE_W    = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic              clk,
  input logic              rst_n,
  mine_placer_ctl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, GEN, READ, CHECK, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [15:0]        lfsr;
  logic [4:0]         dim_r;
  logic [MINE_W-1:0]  mines_r;
  logic [MINE_W-1:0]  placed;
  logic [COORD_W-1:0] safe_x_r;
  logic [COORD_W-1:0] safe_y_r;
  logic [COORD_W-1:0] addr_x;
  logic [COORD_W-1:0] addr_y;
  logic               error_r;

  logic               accept;
  logic               reject;
  logic [10:0]        side;
  logic [10:0]        capacity;
  logic [4:0]         mask;
  logic [COORD_W-1:0] dim_c;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               cand_ok;
  logic               clear_last;
  logic               place_last;

  function automatic logic [4:0] calc_mask(input logic [4:0] d);
    if (d <= 5'd1)       return 5'd1;
    else if (d <= 5'd3)  return 5'd3;
    else if (d <= 5'd7)  return 5'd7;
    else if (d <= 5'd15) return 5'd15;
    else                 return 5'd31;
  endfunction

  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign side     = 11'(bus.dimension_size) + 11'd1;
  assign capacity = side * side - 11'd1;
  assign reject   = (bus.dimension_size == 5'd0) || (11'(bus.mine_count) > capacity);

  // The mask never exceeds 31, so bits 5 and 13 of the LFSR are always masked off.
  assign dim_c      = COORD_W'(dim_r);
  assign mask       = calc_mask(dim_r);
  assign cand_x     = COORD_W'(lfsr[4:0] & mask);
  assign cand_y     = COORD_W'(lfsr[12:8] & mask);
  assign cand_ok    = (cand_x <= dim_c) && (cand_y <= dim_c) &&
                      !((cand_x == safe_x_r) && (cand_y == safe_y_r));
  assign clear_last = (addr_x == dim_c) && (addr_y == dim_c);
  assign place_last = (placed + MINE_W'(1)) == mines_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = reject ? DONE : CLEAR;
      CLEAR:      if (clear_last) state_nxt = (mines_r == '0) ? DONE : GEN;
      GEN:        if (cand_ok) state_nxt = READ;
      READ:       state_nxt = CHECK;
      CHECK:      state_nxt = bus.cell_rdata ? GEN : WRITE;
      WRITE:      state_nxt = place_last ? DONE : GEN;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = 1'b0;
    bus.cell_we    = 1'b0;
    bus.cell_wdata = 1'b0;
    bus.cell_rd_en = 1'b0;
    bus.done       = 1'b0;
    case (state)
      CLEAR: begin bus.busy = 1'b1; bus.cell_we = 1'b1; end
      GEN:   bus.busy = 1'b1;
      READ:  begin bus.busy = 1'b1; bus.cell_rd_en = 1'b1; end
      CHECK: bus.busy = 1'b1;
      WRITE: begin bus.busy = 1'b1; bus.cell_we = 1'b1; bus.cell_wdata = 1'b1; end
      DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // The address register doubles as the sweep counter and as the registered candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= LFSR_SEED;
      dim_r    <= '0;
      mines_r  <= '0;
      placed   <= '0;
      safe_x_r <= '0;
      safe_y_r <= '0;
      addr_x   <= '0;
      addr_y   <= '0;
      error_r  <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (accept) begin
        dim_r    <= bus.dimension_size;
        mines_r  <= bus.mine_count;
        safe_x_r <= bus.safe_x;
        safe_y_r <= bus.safe_y;
        placed   <= '0;
        error_r  <= reject;
        if (!reject) begin
          addr_x <= '0;
          addr_y <= '0;
        end
      end else begin
        case (state)
          CLEAR: if (!clear_last) begin
            if (addr_x == dim_c) begin
              addr_x <= '0;
              addr_y <= addr_y + COORD_W'(1);
            end else begin
              addr_x <= addr_x + COORD_W'(1);
            end
          end
          GEN: if (cand_ok) begin
            addr_x <= cand_x;
            addr_y <= cand_y;
          end
          WRITE:   placed <= placed + MINE_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign bus.cell_x = addr_x;
  assign bus.cell_y = addr_y;
  assign bus.error  = error_r;
endmodule

// File: doc/mine_placer_ctl.md
Name: mine_placer_ctl

Overview:
- Sequences board generation for the Saper game board RAM at the start of each game.
- Sweeps every cell in row-major order (x inner, y outer), clearing it.
- Then places `mine_count` distinct mines at pseudorandom cells, never on the player's first-click (safe) cell.
- Sits between the game FSM (start/done handshake) and the board cell memory (write port plus 1-cycle-latency read port).

Parameters:
- COORD_W, 6, width of x/y coordinates.
- MINE_W, 7, width of mine count.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to build a board.
- dimension_size  in  5  max cell index per axis; board is (dimension_size+1)^2 cells.
- mine_count  in  MINE_W  number of mines to place.
- safe_x, safe_y  in  COORD_W  cell that must stay mine-free.
- cell_x, cell_y  out  COORD_W  memory address.
- cell_we  out  1  write strobe, one cell per cycle.
- cell_wdata  out  1  mine flag to write.
- cell_rd_en  out  1  read strobe.
- cell_rdata  in  1  mine flag; valid the cycle after cell_rd_en.
- busy  out  1  high while generating.
- done  out  1  level, board ready.
- error  out  1  level, request rejected.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All outputs 0.
  - LFSR loads LFSR_SEED; placed counter cleared.
  - Applies mid-operation too; a partial board is left as-is.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Free-runs every clock from reset; never reseeded by start.
- start:
  - Accepted only in IDLE or DONE; ignored while busy.
  - On acceptance, latch dimension_size, mine_count, safe_x, safe_y; clear done/error.
  - If dimension_size==0 or mine_count > (d+1)^2-1: go to DONE next cycle with error=1 and no memory access.
  - Otherwise go to CLEAR.
- busy = 1 in CLEAR, GEN, READ, CHECK, WRITE; 0 in IDLE and DONE.
- CLEAR:
  - One write per cycle, cell_we=1, cell_wdata=0.
  - Address runs (0,0),(1,0)…(d,0),(0,1)…(d,d): exactly (d+1)^2 cycles.
  - After (d,d): go to DONE if mine_count==0, else GEN.
- GEN:
  - mask = smallest 2^k-1 >= d (k = 1..5).
  - Candidate cx = lfsr[5:0] & mask, cy = lfsr[13:8] & mask.
  - If cx>d, cy>d, or (cx,cy)==(safe_x,safe_y): stay in GEN and retry next cycle with a new LFSR value.
  - Else register the candidate, drive cell_rd_en=1 with cell_x/cell_y = candidate, go to READ.
- READ: wait one cycle for memory latency; then CHECK.
- CHECK:
  - cell_rdata==1 (duplicate): go to GEN.
  - Else go to WRITE.
- WRITE:
  - cell_we=1, cell_wdata=1 at the candidate; placed++.
  - If placed==mine_count: DONE, else GEN.
- DONE: done=1 (error as set) until the next accepted start or reset.
- Strobe timing:
  - cell_we and cell_rd_en are never high in the same cycle.
  - cell_x/cell_y are meaningful only while a strobe is high; they hold their previous value otherwise.
- Cost per mine: minimum 4 cycles (GEN, READ, CHECK, WRITE); unbounded only through LFSR retries.
- Placed counter is MINE_W bits; no wrap is possible because of the capacity check.

Test Plan:
- d=3, mines=0, start → 16 consecutive writes of 0 in row-major order (0,0)…(3,3).
  - busy high 16 cycles; done=1 on the next cycle; no reads.
- d=3, mines=15, safe=(1,2) with a RAM model → exactly 15 writes of 1, all distinct, none at (1,2).
  - All 16 cells visited by CLEAR; final board has 15 mines; done=1, error=0.
- d=2, mines=9 (capacity is 8) → error=1 and done=1 one cycle after start.
  - Zero cell_we/cell_rd_en pulses; busy never rises.
- d=7, mines=10, RAM preloaded by the scoreboard is ignored (CLEAR overwrites it); force several duplicate candidates → no second write of 1 to any cell.
  - Every write preceded by rd_en 2 cycles earlier at the same address.
- rst_n pulled low at cycle 5 of CLEAR → all outputs 0 asynchronously, before the next clock edge.
  - After release, a new start (d=1, mines=3, safe=(0,0)) yields mines at (1,0),(0,1),(1,1).
- start pulsed during GEN → ignored, no restart; start in DONE → done drops next cycle and CLEAR restarts at (0,0).
